// File: rtl/fp_pkg.sv
// Shared floating-point definitions used by the FP datapath blocks.
// Holds the IEEE-754 single-precision field widths and the converter state type.
package fp_pkg;

    localparam int unsigned FP_BIAS   = 127;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } i2f_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Rounds a normalised 32-bit magnitude (bit 31 set) to 24 significant bits
// using round-to-nearest-even, then packs sign, exponent and fraction.
module fp32_round_pack
    import fp_pkg::*;
(
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp_in,
    input  logic [31:0]         mag,
    output logic [31:0]         word,
    output logic                inexact
);

    logic [FP_FRAC_W-1:0] frac;
    logic                 guard_bit;
    logic                 sticky_bit;
    logic                 round_up;
    logic [FP_FRAC_W:0]   frac_rnd;
    logic [FP_EXP_W-1:0]  exp_out;

    always_comb begin
        frac       = mag[30:8];
        guard_bit  = mag[7];
        sticky_bit = |mag[6:0];
        round_up   = guard_bit & (sticky_bit | frac[0]);
        frac_rnd   = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, round_up};
        exp_out    = exp_in;
        // A carry out of the fraction leaves frac_rnd[22:0] at zero; only the exponent moves.
        if (frac_rnd[FP_FRAC_W]) begin
            exp_out = exp_in + 8'd1;
        end
        word    = {sign, exp_out, frac_rnd[FP_FRAC_W-1:0]};
        inexact = guard_bit | sticky_bit;
    end

endmodule

// File: rtl/int_to_fp32.sv
// Sequential 32-bit integer to IEEE-754 single converter: captures the magnitude,
// normalises it one bit per cycle, then rounds to nearest-even and holds the result.
module int_to_fp32
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + 31);

    i2f_state_t    state_q, state_d;
    logic [31:0]   mag_q, mag_d;
    logic [4:0]    k_q, k_d;
    logic          sign_q, sign_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_inexact_q, out_inexact_d;

    logic [FP_EXP_W-1:0] round_exp;
    logic [31:0]         round_word;
    logic                round_inexact;

    assign round_exp = EXP_TOP - {3'b000, k_q};

    fp32_round_pack u_round_pack (
        .sign    (sign_q),
        .exp_in  (round_exp),
        .mag     (mag_q),
        .word    (round_word),
        .inexact (round_inexact)
    );

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;

    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        k_d           = k_q;
        sign_d        = sign_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_signed & in_data[31];
                    // Two's complement negate; 0x80000000 maps onto itself as intended.
                    mag_d   = (in_signed & in_data[31]) ? (~in_data + 32'd1) : in_data;
                    k_d     = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    out_data_d    = '0;
                    out_inexact_d = 1'b0;
                    state_d       = DONE;
                end else if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    k_d   = k_q + 5'd1;
                end
            end
            ROUND: begin
                out_data_d    = round_word;
                out_inexact_d = round_inexact;
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            k_q           <= '0;
            sign_q        <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            k_q           <= k_d;
            sign_q        <= sign_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end

endmodule

// File: tb/tb_int_to_fp32.sv
// Scoreboard bench for int_to_fp32: a driver pushes model results into a queue and
// an independent monitor pops and compares whenever the converter presents a result.
module tb_int_to_fp32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    int_to_fp32 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        inx;
        int          lat;
        int          t;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   force_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference conversion from the arithmetic definition of round-to-nearest-even.
    function automatic void model(input logic [31:0] d, input logic sg,
                                  output logic [31:0] res, output logic inx, output int lat);
        longint m, q, rem, half;
        int     p, sh;
        logic   neg;
        neg = sg & d[31];
        m   = neg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
        inx = 1'b0;
        if (m == 0) begin
            res = 32'h0;
            lat = 2;
            return;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        lat = (31 - p) + 3;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        res = {neg, 8'(127 + p), q[22:0]};
    endfunction

    // exp_lat < 0 takes the latency from the model; use_model = 0 uses the given constants.
    task automatic send(input string name, input logic [31:0] d, input logic sg,
                        input bit use_model, input logic [31:0] xd, input logic xi, input int xl);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({name, " accept timeout"}, 32'(in_ready), 32'(1));
            return;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sg;
        model(d, sg, e.data, e.inx, e.lat);
        if (!use_model) begin
            e.data = xd;
            e.inx  = xi;
        end
        if (xl >= 0) e.lat = xl;
        e.t    = cyc;
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", 32'(sb.size()), 32'(0));
    endtask

    // Monitor: pops on the first cycle a result is presented, then rechecks while held.
    initial begin
        bit   have = 1'b0;
        bit   chk_rdy = 1'b0;
        exp_t cur;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have      = 1'b0;
                chk_rdy   = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (chk_rdy) begin
                    chk("in_ready after handshake", 32'(in_ready), 32'(1));
                    chk_rdy = 1'b0;
                end
                if (out_valid) begin
                    if (!have) begin
                        if (sb.size() == 0) begin
                            chk("unexpected out_valid", 32'(out_valid), 32'(0));
                        end else begin
                            cur  = sb.pop_front();
                            have = 1'b1;
                            chk({cur.name, " latency"}, 32'(cyc - cur.t), 32'(cur.lat));
                        end
                    end
                    if (have) begin
                        chk({cur.name, " data"}, out_data, cur.data);
                        chk({cur.name, " inexact"}, 32'(out_inexact), 32'(cur.inx));
                        chk({cur.name, " in_ready while done"}, 32'(in_ready), 32'(0));
                    end
                    out_ready = force_stall ? 1'b0 : 1'($urandom_range(0, 1));
                    if (out_ready) begin
                        have    = 1'b0;
                        chk_rdy = 1'b1;
                    end
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] d;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'(0));
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_inexact", 32'(out_inexact), 32'(0));
        chk("reset in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 32'(1));

        send("s1",        32'h0000_0001, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 34);
        send("s-1",       32'hFFFF_FFFF, 1'b1, 1'b0, 32'hBF80_0000, 1'b0, 34);
        send("smin",      32'h8000_0000, 1'b1, 1'b0, 32'hCF00_0000, 1'b0, 3);
        send("smax",      32'h7FFF_FFFF, 1'b1, 1'b0, 32'h4F00_0000, 1'b1, -1);
        send("tie_down",  32'd16777217,  1'b0, 1'b0, 32'h4B80_0000, 1'b1, -1);
        send("tie_up",    32'd16777219,  1'b0, 1'b0, 32'h4B80_0002, 1'b1, -1);
        send("umax",      32'hFFFF_FFFF, 1'b0, 1'b0, 32'h4F80_0000, 1'b1, 3);
        send("zero_s",    32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 2);
        send("zero_u",    32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b0, 2);
        send("u_msb",     32'h8000_0000, 1'b0, 1'b0, 32'h4F00_0000, 1'b0, 3);
        drain();

        // Backpressure: result must hold for ten stalled cycles.
        force_stall = 1'b1;
        send("bp", 32'h1234_5679, 1'b0, 1'b1, '0, 1'b0, -1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp out_valid arrives", 32'(out_valid), 32'(1));
        repeat (10) begin
            @(negedge clk);
            chk("bp out_valid held", 32'(out_valid), 32'(1));
        end
        force_stall = 1'b0;
        drain();

        // Reset during normalisation abandons the conversion.
        send("rst_victim", 32'h1, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid-rst out_valid", 32'(out_valid), 32'(0));
        chk("mid-rst in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 32'(1));
        chk("post-rst out_valid", 32'(out_valid), 32'(0));
        send("three", 32'h3, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 33);
        drain();

        for (int i = 0; i < 50; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = -d;
            send("rand", d, 1'($urandom_range(0, 1)), 1'b1, '0, 1'b0, -1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_to_fp32.md
# int_to_fp32

Sequential converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision value, rounded to nearest-even. It is the producer end of the floating-point datapath: integer results from the fixed-point side are encoded into the 32-bit format consumed by the FP ALU. A one-bit-per-cycle normaliser keeps area small, and valid/ready handshakes on both sides allow stalls.

## Interface
- No parameters; widths are fixed at 32-bit in and 32-bit out.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  converter can accept; high only in IDLE.
- `in_data`  in  32  integer operand.
- `in_signed`  in  1  1: `in_data` is two's complement; 0: unsigned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  IEEE-754 result as {sign, exp[7:0], frac[22:0]}.
- `out_inexact`  out  1  rounding discarded non-zero bits.

## Operation
- The FSM has four states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - On `in_valid & in_ready`, capture `sign = in_signed & in_data[31]`.
  - Capture `mag` (32-bit unsigned) as `sign ? -in_data : in_data`. 0x80000000 signed gives mag 0x80000000.
  - Clear `k` (5-bit shift count) and go to NORM.
- NORM:
  - If `mag == 0`, load result 0x00000000 with inexact 0 and go to DONE. Zero is always +0.
  - Else if `mag[31]`, go to ROUND.
  - Else shift `mag <<= 1`, `k <= k+1`, and stay in NORM.
- ROUND:
  - Exponent is `exp = 158 - k` (127 + 31 - k), giving a range of 127..158. It never overflows and never produces a denormal.
  - Fields: `frac = mag[30:8]`, `G = mag[7]`, `S = |mag[6:0]`.
  - Round up when `G & (S | frac[0])`.
  - If the increment carries out of 23 bits, set frac to 0 and `exp+1`.
  - Register `out_data = {sign, exp, frac}` and `out_inexact = G | S`, then go to DONE.
- DONE:
  - `out_valid = 1`. `out_data` and `out_inexact` stay stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready = (state == IDLE) & ~rst`. There is one conversion in flight at a time.
- Changes on the input side outside a handshake have no effect.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid` 0, `out_data` 32'h0, `out_inexact` 0.
  - `in_ready` is 0 while `rst` is high and 1 in the cycle after `rst` falls.
- Latency, with T the accept cycle and k the leading zero count of mag:
  - Non-zero input: `out_valid` first high in cycle T+k+3. The range is T+3 (bit 31 set) to T+34 (mag = 1).
  - Zero input: `out_valid` first high in cycle T+2.
- Backpressure: DONE holds indefinitely while `out_ready = 0`, and `out_data` must not change.
- Throughput:
  - The result handshake happens in cycle D. `in_ready` is high in D+1, so the earliest next accept is D+1.
  - There is no same-cycle bypass.
- `out_ready` asserted before `out_valid` is ignored.
- Reset mid-operation (any state): the conversion is abandoned, outputs return to reset values on the next edge, and no partial result is ever presented.
- `in_signed = 0` with `in_data[31] = 1` is a plain unsigned value (sign 0, exp 158).

## Structure
- Shared package `fp_pkg`:
  - `FP_BIAS = 127`, `FP_EXP_W = 8`, `FP_FRAC_W = 23`.
  - State enum `i2f_state_t` {IDLE, NORM, ROUND, DONE}.
  - The same package serves the FP ALU and future FP blocks.
- Sub-module `fp32_round_pack`:
  - Combinational; inputs sign, exp, normalised 32-bit mag.
  - Outputs packed word and inexact.
  - Reusable for a future float-result rounding stage.
- Top level holds the FSM, shift register, counter and output registers.

## Test plan
- Signed 1 → `out_data` 0x3F800000, inexact 0, `out_valid` at T+34. Signed -1 → 0xBF800000.
- Signed 0x80000000 → 0xCF000000, inexact 0, `out_valid` at T+3. Signed 0x7FFFFFFF → 0x4F000000, inexact 1.
- Ties: 16777217 → 0x4B800000 (tie to even, down). 16777219 → 0x4B800002 (tie to even, up). Both inexact 1.
- Unsigned 0xFFFFFFFF → 0x4F800000, inexact 1 (rounding carry bumps exp to 159). Zero → 0x00000000 at T+2.
- Backpressure: hold `out_ready = 0` for 10 cycles → `out_valid` stays high, data stable, `in_ready` low. Release → handshake, then `in_ready` high the next cycle.
- Assert `rst` during NORM of input 1 → next cycle `out_valid` 0 and state IDLE. Then a fresh input 3 → 0x40400000 with correct latency (k=30, T+33).
